// File: rtl/spike_event_encoder_if.sv
// Event stream from the spike encoder toward the readout/AER link.
// The master presents the head event and the slave accepts it.
interface spike_event_encoder_if #(
  parameter int TS_W = 16
);
  logic            evt_valid;
  logic            evt_ready;
  logic [TS_W-1:0] evt_ts;

  modport master (
    output evt_valid,
    output evt_ts,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ts,
    output evt_ready
  );
endinterface

// File: rtl/spike_event_encoder.sv
// Turns rising edges of the lif spike level into timestamped events,
// queues them in a small FIFO, and keeps a per-window spike-rate count.
module spike_event_encoder #(
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RATE_WIN   = 256,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spike,
  input  logic                  enable,
  input  logic                  clr_ovf,
  spike_event_encoder_if.master evt,
  output logic                  evt_ovf,
  output logic [CNT_W-1:0]      rate_count,
  output logic                  rate_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(RATE_WIN);

  logic              spike_q;
  logic [TS_W-1:0]   ts;
  logic [TS_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       used;
  logic [WW-1:0]     win_cnt;
  logic [CNT_W-1:0]  edge_cnt;

  logic              edge_det;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              win_last;
  logic [CNT_W-1:0]  cnt_next;

  assign edge_det = enable & spike & ~spike_q;
  assign full     = used == (AW+1)'(FIFO_DEPTH);
  assign empty    = used == '0;
  assign pop      = !empty && evt.evt_ready;
  // A pop frees the slot a same-cycle push needs, so full+pop still accepts.
  assign push     = edge_det && (!full || pop);
  assign win_last = win_cnt == WW'(RATE_WIN - 1);

  assign cnt_next = (edge_det && edge_cnt != '1)
                  ? edge_cnt + CNT_W'(1)
                  : edge_cnt;

  assign evt.evt_valid = !empty;
  assign evt.evt_ts    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_q <= 1'b0;
      ts      <= '0;
    end else begin
      spike_q <= spike;
      ts      <= ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ts;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end

  // A drop takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      evt_ovf <= 1'b0;
    else if (edge_det && !push)
      evt_ovf <= 1'b1;
    else if (clr_ovf)
      evt_ovf <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
    end else if (win_last) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      rate_count <= cnt_next;
      rate_valid <= 1'b1;
    end else begin
      win_cnt    <= win_cnt + WW'(1);
      edge_cnt   <= cnt_next;
      rate_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder using three parameter sets
// that share clock, reset and spike stimulus.
module tb_spike_event_encoder;

  logic clk;
  logic reset_n;
  logic spike;
  logic enable;
  logic clr_ovf;
  logic ready;

  int passed = 0;
  int total  = 0;

  spike_event_encoder_if #(.TS_W(16)) ia ();
  spike_event_encoder_if #(.TS_W(16)) ib ();
  spike_event_encoder_if #(.TS_W(4))  ic ();

  assign ia.evt_ready = ready;
  assign ib.evt_ready = ready;
  assign ic.evt_ready = ready;

  logic       a_ovf, b_ovf, c_ovf;
  logic [7:0] a_rc, b_rc;
  logic [2:0] c_rc;
  logic       a_rv, b_rv, c_rv;

  spike_event_encoder #(
    .TS_W(16), .FIFO_DEPTH(4), .RATE_WIN(8), .CNT_W(8)
  ) ua (
    .clk(clk), .reset_n(reset_n), .spike(spike),
    .enable(enable), .clr_ovf(clr_ovf), .evt(ia),
    .evt_ovf(a_ovf), .rate_count(a_rc), .rate_valid(a_rv)
  );

  spike_event_encoder #(
    .TS_W(16), .FIFO_DEPTH(4), .RATE_WIN(16), .CNT_W(8)
  ) ub (
    .clk(clk), .reset_n(reset_n), .spike(spike),
    .enable(enable), .clr_ovf(clr_ovf), .evt(ib),
    .evt_ovf(b_ovf), .rate_count(b_rc), .rate_valid(b_rv)
  );

  spike_event_encoder #(
    .TS_W(4), .FIFO_DEPTH(4), .RATE_WIN(16), .CNT_W(3)
  ) uc (
    .clk(clk), .reset_n(reset_n), .spike(spike),
    .enable(enable), .clr_ovf(clr_ovf), .evt(ic),
    .evt_ovf(c_ovf), .rate_count(c_rc), .rate_valid(c_rv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Leaves us mid-cycle; the next rising edge samples ts=0.
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [15:0] exp3 [4];
  logic [15:0] exp4 [4];

  initial begin
    exp3 = '{16'd3, 16'd5, 16'd7, 16'd9};
    exp4 = '{16'd5, 16'd7, 16'd9, 16'd20};
    reset_n = 1'b0;
    spike   = 1'b0;
    enable  = 1'b1;
    clr_ovf = 1'b0;
    ready   = 1'b1;

    // spike held high through reset
    spike = 1'b1;
    do_reset();
    chk("rst_valid", ia.evt_valid, 0);
    chk("rst_ts", ia.evt_ts, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_rate_count", a_rc, 0);
    chk("rst_rate_valid", a_rv, 0);
    tick();
    chk("t1_valid", ia.evt_valid, 1);
    chk("t1_ts", ia.evt_ts, 0);
    tick();
    chk("t1_one_cycle", ia.evt_valid, 0);
    repeat (3) tick();
    chk("t1_no_more", ia.evt_valid, 0);

    // disabled edges produce nothing
    spike  = 1'b0;
    enable = 1'b0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      spike = (k < 6) && (k % 2 == 0);
      tick();
      chk("t2_dis_valid", ia.evt_valid, 0);
    end
    chk("t2_rate_valid", a_rv, 1);
    chk("t2_rate_zero", a_rc, 0);
    enable = 1'b1;
    spike  = 1'b0;
    tick();
    tick();
    spike = 1'b1;
    tick();
    chk("t2_valid", ia.evt_valid, 1);
    chk("t2_ts10", ia.evt_ts, 10);

    // overflow with stalled consumer; drop beats clear
    spike = 1'b0;
    ready = 1'b0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      spike   = (k >= 3) && (k % 2 == 1);
      clr_ovf = (k == 11);
      tick();
      if (k == 3) chk("t3_first_ts", ia.evt_ts, 3);
      if (k == 9) chk("t3_ovf_before", a_ovf, 0);
    end
    spike   = 1'b0;
    clr_ovf = 1'b0;
    chk("t3_ovf", a_ovf, 1);
    chk("t3_head", ia.evt_ts, 3);
    tick();
    chk("t3_stable", ia.evt_ts, 3);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", ia.evt_valid, 1);
      chk("t3_drain_ts", ia.evt_ts, exp3[i]);
      tick();
    end
    chk("t3_empty", ia.evt_valid, 0);
    chk("t3_ovf_held", a_ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", a_ovf, 0);

    // full FIFO, push and pop together
    ready = 1'b0;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      spike = (k == 3) || (k == 5) || (k == 7) ||
              (k == 9) || (k == 20);
      ready = (k == 20);
      tick();
    end
    spike = 1'b0;
    ready = 1'b0;
    chk("t4_ovf", a_ovf, 0);
    chk("t4_head", ia.evt_ts, 5);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_ts", ia.evt_ts, exp4[i]);
      tick();
    end
    chk("t4_empty", ia.evt_valid, 0);

    // rate window with 8 edges in 16 cycles
    ready = 1'b1;
    spike = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      spike = (k % 2 == 0);
      tick();
      if (k == 14) chk("t5_rv_early", b_rv, 0);
    end
    chk("t5_rate_valid", b_rv, 1);
    chk("t5_rate_count", b_rc, 8);
    chk("t5_sat_valid", c_rv, 1);
    chk("t5_sat_count", c_rc, 7);
    spike = 1'b0;
    tick();
    chk("t5_rv_pulse", b_rv, 0);
    chk("t5_rc_hold", b_rc, 8);

    // timestamp wrap and reset flush
    ready = 1'b0;
    spike = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      spike = (k == 17) || (k == 19);
      tick();
      if (k == 17) begin
        chk("t6_valid", ic.evt_valid, 1);
        chk("t6_wrap_ts", ic.evt_ts, 1);
      end
    end
    chk("t6_head_hold", ic.evt_ts, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_flush", ic.evt_valid, 0);
    chk("t6_async_ts", ic.evt_ts, 0);
    spike = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_after_rst", ic.evt_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
